// File: rtl/floating_point_divider_pkg.sv
// Shared definitions for the custom float {sign, exponent, mantissa} arithmetic units:
// default field widths, exponent bias helper, status flag positions and divider FSM states.
package floating_point_pkg;

   localparam int DEF_NB_SIGN = 1;
   localparam int DEF_NB_EXPO = 4;
   localparam int DEF_NB_MANT = 8;

   localparam int FLAG_DIV_ZERO  = 2;
   localparam int FLAG_OVERFLOW  = 1;
   localparam int FLAG_UNDERFLOW = 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      NORM   = 2'd2,
      DONE   = 2'd3
   } divState_t;

   function automatic int calcBias(input int nbExpo);
      return (1 << (nbExpo - 1)) - 1;
   endfunction

endpackage

// File: rtl/floating_point_divider_core.sv
// Restoring significand divider: produces NB_MANT+3 quotient bits of {1,mA}/{1,mB},
// one per cycle, plus a sticky flag for any nonzero final remainder.
module mantissa_divider_core #(
   parameter int NB_MANT = 8
) (
   input  logic               clk,
   input  logic               i_rst,
   input  logic               start,
   input  logic [NB_MANT:0]   dividend,
   input  logic [NB_MANT:0]   divisor,
   output logic               done,
   output logic [NB_MANT+2:0] quotient,
   output logic               sticky
);

   localparam int NB_QUO = NB_MANT + 3;
   localparam int NB_CNT = $clog2(NB_QUO + 1);
   localparam logic [NB_CNT-1:0] LAST_STEP = NB_CNT'(NB_QUO - 1);

   logic [NB_MANT+1:0] remainder;
   logic [NB_MANT+1:0] diff;
   logic [NB_MANT:0]   divisorReg;
   logic [NB_CNT-1:0]  count;
   logic               busy;
   logic               fits;

   always_comb begin
      fits = remainder >= {1'b0, divisorReg};
      diff = remainder - {1'b0, divisorReg};
   end

   // done marks the final iteration; quotient and sticky are settled from the next cycle on
   assign done   = busy && (count == LAST_STEP);
   assign sticky = |remainder;

   always_ff @(posedge clk or negedge i_rst) begin
      if (!i_rst) begin
         remainder  <= '0;
         divisorReg <= '0;
         quotient   <= '0;
         count      <= '0;
         busy       <= 1'b0;
      end else if (start) begin
         remainder  <= {1'b0, dividend};
         divisorReg <= divisor;
         quotient   <= '0;
         count      <= '0;
         busy       <= 1'b1;
      end else if (busy) begin
         quotient  <= {quotient[NB_QUO-2:0], fits};
         remainder <= (fits ? diff : remainder) << 1;
         count     <= count + 1'b1;
         if (count == LAST_STEP) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/floating_point_divider.sv
// Iterative float divider o_data = A / B with valid/ready handshake and fixed latency.
// Define FPDIV_ROUND_NEAREST_EN for round-to-nearest-even; otherwise the result is truncated.
module floating_point_divider
   import floating_point_pkg::*;
#(
   parameter int NB_SIGN = DEF_NB_SIGN,
   parameter int NB_EXPO = DEF_NB_EXPO,
   parameter int NB_MANT = DEF_NB_MANT
) (
   input  logic                              clk,
   input  logic                              i_rst,
   input  logic                              i_valid,
   output logic                              o_ready,
   input  logic [NB_SIGN+NB_EXPO+NB_MANT-1:0] i_dataA,
   input  logic [NB_SIGN+NB_EXPO+NB_MANT-1:0] i_dataB,
   output logic                              o_valid,
   input  logic                              i_ready,
   output logic [NB_SIGN+NB_EXPO+NB_MANT-1:0] o_data,
   output logic [2:0]                        o_flags
);

   localparam int NB    = NB_SIGN + NB_EXPO + NB_MANT;
   localparam int NB_EQ = NB_EXPO + 2;
   localparam logic signed [NB_EQ-1:0] BIAS_EQ = NB_EQ'(calcBias(NB_EXPO));
   localparam logic signed [NB_EQ-1:0] EXP_MAX = NB_EQ'((1 << NB_EXPO) - 1);
   localparam logic signed [NB_EQ-1:0] ONE_EQ  = NB_EQ'(1);

   divState_t                state;
   logic                     signQ;
   logic signed [NB_EQ-1:0]  expQ;
   logic                     zeroA;
   logic                     zeroB;
   logic                     accept;
   logic                     coreDone;
   logic [NB_MANT+2:0]       quotient;
   logic                     coreSticky;

   logic                     intBit;
   logic [NB_MANT-1:0]       mantRaw;
   logic                     guardBit;
   logic                     stickyBit;
   logic                     roundUp;
   logic [NB_MANT:0]         mantSum;
   logic signed [NB_EQ-1:0]  expNorm;
   logic signed [NB_EQ-1:0]  expFinal;
   logic [NB-1:0]            resData;
   logic [2:0]               resFlags;

   assign accept = (state == IDLE) && i_valid;

   mantissa_divider_core #(.NB_MANT(NB_MANT)) uCore (
      .clk      (clk),
      .i_rst    (i_rst),
      .start    (accept),
      .dividend ({1'b1, i_dataA[NB_MANT-1:0]}),
      .divisor  ({1'b1, i_dataB[NB_MANT-1:0]}),
      .done     (coreDone),
      .quotient (quotient),
      .sticky   (coreSticky)
   );

   // A quotient below 1.0 is renormalised by one place, pulling one more bit into the mantissa
   always_comb begin
      intBit    = quotient[NB_MANT+2];
      mantRaw   = intBit ? quotient[NB_MANT+1:2] : quotient[NB_MANT:1];
      guardBit  = intBit ? quotient[1] : quotient[0];
      stickyBit = coreSticky | (intBit & quotient[0]);
      expNorm   = intBit ? expQ : expQ - ONE_EQ;
   end

`ifdef FPDIV_ROUND_NEAREST_EN
   assign roundUp = guardBit & (stickyBit | mantRaw[0]);
`else
   logic unusedRoundBits;
   assign roundUp         = 1'b0;
   assign unusedRoundBits = guardBit | stickyBit;
`endif

   always_comb begin
      mantSum  = {1'b0, mantRaw} + {{NB_MANT{1'b0}}, roundUp};
      expFinal = expNorm + (mantSum[NB_MANT] ? ONE_EQ : '0);
      resData  = {signQ, expFinal[NB_EXPO-1:0], mantSum[NB_MANT-1:0]};
      resFlags = '0;
      if (zeroB) begin
         resData                 = {signQ, {NB_EXPO{1'b1}}, {NB_MANT{1'b1}}};
         resFlags[FLAG_DIV_ZERO] = 1'b1;
      end else if (zeroA) begin
         resData = {signQ, {(NB - 1){1'b0}}};
      end else if (expFinal > EXP_MAX) begin
         resData                 = {signQ, {NB_EXPO{1'b1}}, {NB_MANT{1'b1}}};
         resFlags[FLAG_OVERFLOW] = 1'b1;
      end else if (expFinal < ONE_EQ) begin
         resData                  = {signQ, {(NB - 1){1'b0}}};
         resFlags[FLAG_UNDERFLOW] = 1'b1;
      end
   end

   // Handshake FSM; the core runs alongside DIVIDE and results are registered on leaving NORM
   always_ff @(posedge clk or negedge i_rst) begin
      if (!i_rst) begin
         state   <= IDLE;
         o_ready <= 1'b1;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_flags <= '0;
         signQ   <= 1'b0;
         expQ    <= '0;
         zeroA   <= 1'b0;
         zeroB   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  signQ   <= i_dataA[NB-1] ^ i_dataB[NB-1];
                  expQ    <= {2'b00, i_dataA[NB_MANT +: NB_EXPO]}
                             - {2'b00, i_dataB[NB_MANT +: NB_EXPO]} + BIAS_EQ;
                  zeroA   <= (i_dataA[NB_MANT +: NB_EXPO] == '0);
                  zeroB   <= (i_dataB[NB_MANT +: NB_EXPO] == '0);
                  o_ready <= 1'b0;
                  state   <= DIVIDE;
               end
            end
            DIVIDE: begin
               if (coreDone) begin
                  state <= NORM;
               end
            end
            NORM: begin
               o_data  <= resData;
               o_flags <= resFlags;
               o_valid <= 1'b1;
               state   <= DONE;
            end
            DONE: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  o_ready <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_floating_point_divider.sv
// Self-checking bench for floating_point_divider: directed corner cases plus random operands
// compared with an exact-arithmetic reference model.
module tb_floating_point_divider;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic [12:0] i_dataA;
   logic [12:0] i_dataB;
   logic        o_valid;
   logic        i_ready;
   logic [12:0] o_data;
   logic [2:0]  o_flags;

   int errorCount = 0;
   int checkCount = 0;

   floating_point_divider dut (
      .clk     (clk),
      .i_rst   (i_rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_dataA (i_dataA),
      .i_dataB (i_dataB),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_flags (o_flags)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Exact quotient of the significands with integer division; rounding from the true remainder
   function automatic void refModel(input logic [12:0] a, input logic [12:0] b,
                                    output logic [12:0] data, output logic [2:0] flags);
      int   eA, eB, sigA, sigB, eq, num, mant, rem;
      logic s;
      s     = a[12] ^ b[12];
      eA    = int'(a[11:8]);
      eB    = int'(b[11:8]);
      flags = 3'b000;
      if (eB == 0) begin
         data  = {s, 4'hF, 8'hFF};
         flags = 3'b100;
         return;
      end
      if (eA == 0) begin
         data = {s, 12'h000};
         return;
      end
      sigA = 256 + int'(a[7:0]);
      sigB = 256 + int'(b[7:0]);
      eq   = eA - eB + 7;
      if (sigA >= sigB) begin
         num = sigA * 256;
      end else begin
         num = sigA * 512;
         eq  = eq - 1;
      end
      mant = num / sigB;
      rem  = num % sigB;
`ifdef FPDIV_ROUND_NEAREST_EN
      if ((2 * rem > sigB) || ((2 * rem == sigB) && (mant % 2 == 1))) begin
         mant = mant + 1;
      end
`else
      rem = 0;
`endif
      if (mant == 512) begin
         mant = 256;
         eq   = eq + 1;
      end
      if (eq > 15) begin
         data  = {s, 4'hF, 8'hFF};
         flags = 3'b010;
      end else if (eq < 1) begin
         data  = {s, 12'h000};
         flags = 3'b001;
      end else begin
         data = {s, 4'(eq), 8'(mant)};
      end
   endfunction

   // One full transaction: accept, bounded wait for o_valid, optional stall, handoff
   task automatic applyStimulus(input logic [12:0] a, input logic [12:0] b, input int holdCycles,
                                output logic [12:0] gotData, output logic [2:0] gotFlags);
      logic [12:0] expData;
      logic [2:0]  expFlags;
      int          cycles;
      refModel(a, b, expData, expFlags);
      i_dataA = a;
      i_dataB = b;
      i_valid = 1'b1;
      i_ready = 1'b0;
      @(posedge clk); #1;
      i_valid = 1'b0;
      checkOutput("busyReady", 32'(o_ready), 32'd0);
      cycles = 0;
      while (!o_valid && cycles < 40) begin
         @(posedge clk); #1;
         cycles++;
      end
      checkOutput("latency", cycles, 12);
      gotData  = o_data;
      gotFlags = o_flags;
      checkOutput("data", 32'(o_data), 32'(expData));
      checkOutput("flags", 32'(o_flags), 32'(expFlags));
      if (holdCycles > 0) begin
         i_valid = 1'b1;
         i_dataA = ~a;
         i_dataB = ~b;
         for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk); #1;
            checkOutput("holdValid", 32'(o_valid), 32'd1);
            checkOutput("holdData", 32'(o_data), 32'(expData));
            checkOutput("holdFlags", 32'(o_flags), 32'(expFlags));
            checkOutput("holdReady", 32'(o_ready), 32'd0);
         end
         i_valid = 1'b0;
      end
      i_ready = 1'b1;
      @(posedge clk); #1;
      i_ready = 1'b0;
      checkOutput("handoffValid", 32'(o_valid), 32'd0);
      checkOutput("handoffReady", 32'(o_ready), 32'd1);
   endtask

   logic [12:0] gd;
   logic [2:0]  gf;
   logic [12:0] ra;
   logic [12:0] rb;

   initial begin
      i_rst   = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_dataA = '0;
      i_dataB = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstReady", 32'(o_ready), 32'd1);
      checkOutput("rstValid", 32'(o_valid), 32'd0);
      checkOutput("rstData", 32'(o_data), 32'd0);
      checkOutput("rstFlags", 32'(o_flags), 32'd0);
      i_rst = 1'b1;
      @(posedge clk); #1;

      applyStimulus(13'h0980, 13'h0800, 0, gd, gf);
      checkOutput("d6div2", 32'(gd), 32'h0880);
      checkOutput("d6div2F", 32'(gf), 32'd0);

      applyStimulus(13'h0740, 13'h0780, 5, gd, gf);
`ifdef FPDIV_ROUND_NEAREST_EN
      checkOutput("dRound", 32'(gd), 32'h06AB);
`else
      checkOutput("dRound", 32'(gd), 32'h06AA);
`endif

      applyStimulus(13'h1980, 13'h0800, 0, gd, gf);
      checkOutput("dNeg", 32'(gd), 32'h1880);

      applyStimulus(13'h0880, 13'h0000, 0, gd, gf);
      checkOutput("dDivZero", 32'(gd), 32'h0FFF);
      checkOutput("dDivZeroF", 32'(gf), 32'h4);

      applyStimulus(13'h0FFF, 13'h0100, 0, gd, gf);
      checkOutput("dOvf", 32'(gd), 32'h0FFF);
      checkOutput("dOvfF", 32'(gf), 32'h2);

      applyStimulus(13'h0100, 13'h0FFF, 0, gd, gf);
      checkOutput("dUnf", 32'(gd), 32'h0000);
      checkOutput("dUnfF", 32'(gf), 32'h1);

      applyStimulus(13'h1000, 13'h0880, 0, gd, gf);
      checkOutput("dZeroA", 32'(gd), 32'h1000);
      checkOutput("dZeroAF", 32'(gf), 32'd0);

      applyStimulus(13'h0000, 13'h0000, 0, gd, gf);
      checkOutput("dZeroZero", 32'(gd), 32'h0FFF);
      checkOutput("dZeroZeroF", 32'(gf), 32'h4);

      for (int n = 0; n < 40; n++) begin
         ra = 13'($urandom);
         rb = 13'($urandom);
         if ($urandom_range(0, 9) == 0) ra[11:8] = 4'h0;
         if ($urandom_range(0, 9) == 0) rb[11:8] = 4'h0;
         applyStimulus(ra, rb, int'($urandom_range(0, 2)), gd, gf);
      end

      // Abort an operation mid-DIVIDE; previous result in o_data must be wiped at once
      applyStimulus(13'h0980, 13'h0800, 0, gd, gf);
      i_dataA = 13'h0FFF;
      i_dataB = 13'h0100;
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      i_rst = 1'b0;
      #1;
      checkOutput("midRstReady", 32'(o_ready), 32'd1);
      checkOutput("midRstValid", 32'(o_valid), 32'd0);
      checkOutput("midRstData", 32'(o_data), 32'd0);
      checkOutput("midRstFlags", 32'(o_flags), 32'd0);
      #2;
      i_rst = 1'b1;
      @(posedge clk); #1;
      applyStimulus(13'h0980, 13'h0800, 0, gd, gf);
      checkOutput("afterRst", 32'(gd), 32'h0880);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
